// File: rtl/demux1x4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry output register per lane.
// Lane selection is either manual (s) or round-robin over accepted beats (auto).
module demux1x4_stream #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     s,
    input  logic           auto,
    output logic [4*W-1:0] y_data,
    output logic [3:0]     y_valid,
    input  logic [3:0]     y_ready,
    output logic [1:0]     cur_sel
);

    logic [W-1:0] lane_data [4];
    logic [3:0]   lane_valid;
    logic [1:0]   rr_ptr;
    logic [1:0]   esel;
    logic         accept;

    // No bypass to other lanes: only the selected lane's occupancy gates the input.
    always_comb begin
        esel     = auto ? rr_ptr : s;
        cur_sel  = esel;
        in_ready = !lane_valid[esel] || y_ready[esel];
        accept   = in_valid && in_ready;
    end

    always_comb begin
        y_data = '0;
        for (int k = 0; k < 4; k++) begin
            y_data[k*W +: W] = lane_data[k];
        end
        y_valid = lane_valid;
    end

    // A load takes priority over a drain of the same lane, so a full lane that
    // drains and reloads on one edge stays valid with the new beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                lane_data[k] <= '0;
            end
            lane_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (esel == 2'(k))) begin
                    lane_data[k]  <= in_data;
                    lane_valid[k] <= 1'b1;
                end else if (lane_valid[k] && y_ready[k]) begin
                    lane_valid[k] <= 1'b0;
                end
            end
            if (accept && auto) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed bench for demux1x4_stream: routing, round-robin, backpressure and reset.
module tb_demux1x4_stream;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     s;
    logic           auto;
    logic [4*W-1:0] y_data;
    logic [3:0]     y_valid;
    logic [3:0]     y_ready;
    logic [1:0]     cur_sel;

    int vectors     = 0;
    int miscompares = 0;

    demux1x4_stream #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .auto     (auto),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .cur_sel  (cur_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] lane(input int k);
        return y_data[k*W +: W];
    endfunction

    // Inputs change 1 time unit after a rising edge; combinational outputs settle before checks.
    task automatic applyStimulus(input logic rn, input logic iv, input logic [W-1:0] d,
                                 input logic [1:0] sel, input logic a, input logic [3:0] yr);
        rst_n    = rn;
        in_valid = iv;
        in_data  = d;
        s        = sel;
        auto     = a;
        y_ready  = yr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 8'hEE, 2'd0, 1'b0, 4'h0);
        tick();
        checkOutput("rst_valid", 32'(y_valid), 32'h0);
        checkOutput("rst_data", y_data, 32'h0);
        checkOutput("rst_ready", 32'(in_ready), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'h0);
        checkOutput("rst_cursel", 32'(cur_sel), 32'h0);
        tick();

        // Manual routing, one beat per lane on consecutive cycles
        applyStimulus(1'b1, 1'b1, 8'hA1, 2'd0, 1'b0, 4'hF);
        checkOutput("man_rdy0", 32'(in_ready), 32'h1);
        tick();
        checkOutput("man_v0", 32'(y_valid), 32'h1);
        checkOutput("man_d0", 32'(lane(0)), 32'hA1);
        applyStimulus(1'b1, 1'b1, 8'hB2, 2'd1, 1'b0, 4'hF);
        checkOutput("man_rdy1", 32'(in_ready), 32'h1);
        tick();
        checkOutput("man_v1", 32'(y_valid), 32'h2);
        checkOutput("man_d1", 32'(lane(1)), 32'hB2);
        applyStimulus(1'b1, 1'b1, 8'hC3, 2'd2, 1'b0, 4'hF);
        checkOutput("man_rdy2", 32'(in_ready), 32'h1);
        tick();
        checkOutput("man_v2", 32'(y_valid), 32'h4);
        checkOutput("man_d2", 32'(lane(2)), 32'hC3);
        applyStimulus(1'b1, 1'b1, 8'hD4, 2'd3, 1'b0, 4'hF);
        checkOutput("man_rdy3", 32'(in_ready), 32'h1);
        tick();
        checkOutput("man_v3", 32'(y_valid), 32'h8);
        checkOutput("man_d3", 32'(lane(3)), 32'hD4);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd3, 1'b0, 4'hF);
        tick();
        checkOutput("drain_v", 32'(y_valid), 32'h0);
        checkOutput("drain_hold", 32'(lane(3)), 32'hD4);

        // Round-robin over six beats, wrapping after lane 3
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i + 1), 2'd0, 1'b1, 4'hF);
            checkOutput("rr_cursel", 32'(cur_sel), 32'(i % 4));
            tick();
            checkOutput("rr_valid", 32'(y_valid), 32'(1 << (i % 4)));
            checkOutput("rr_data", 32'(lane(i % 4)), 32'(i + 1));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
        checkOutput("rr_final", 32'(cur_sel), 32'h2);
        tick();

        // Backpressure on lane 2, then simultaneous drain and load
        applyStimulus(1'b1, 1'b1, 8'h11, 2'd2, 1'b0, 4'hB);
        checkOutput("bp_rdy_a", 32'(in_ready), 32'h1);
        tick();
        checkOutput("bp_v_a", 32'(y_valid), 32'h4);
        applyStimulus(1'b1, 1'b1, 8'h22, 2'd2, 1'b0, 4'hB);
        checkOutput("bp_rdy_b", 32'(in_ready), 32'h0);
        tick();
        checkOutput("bp_hold", 32'(lane(2)), 32'h11);
        checkOutput("bp_v_b", 32'(y_valid), 32'h4);
        applyStimulus(1'b1, 1'b1, 8'h22, 2'd2, 1'b0, 4'hF);
        checkOutput("bp_rdy_c", 32'(in_ready), 32'h1);
        tick();
        checkOutput("bp_v_c", 32'(y_valid), 32'h4);
        checkOutput("bp_new", 32'(lane(2)), 32'h22);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 4'hF);
        tick();

        // Lane independence and no head-of-line bypass
        applyStimulus(1'b1, 1'b1, 8'h77, 2'd0, 1'b0, 4'hE);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h5A, 2'd1, 1'b0, 4'hE);
        checkOutput("ind_rdy1", 32'(in_ready), 32'h1);
        tick();
        checkOutput("ind_v", 32'(y_valid), 32'h3);
        checkOutput("ind_l0", 32'(lane(0)), 32'h77);
        checkOutput("ind_l1", 32'(lane(1)), 32'h5A);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hE);
        checkOutput("ind_rdy0", 32'(in_ready), 32'h0);
        tick();
        checkOutput("ind_drain1", 32'(y_valid), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        tick();

        // Select change while stalled; beat goes to the select of the accept cycle
        applyStimulus(1'b1, 1'b1, 8'h61, 2'd2, 1'b0, 4'hB);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h62, 2'd2, 1'b0, 4'hB);
        checkOutput("sw_stall", 32'(in_ready), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h62, 2'd0, 1'b0, 4'hB);
        checkOutput("sw_rdy", 32'(in_ready), 32'h1);
        tick();
        checkOutput("sw_v", 32'(y_valid), 32'h5);
        checkOutput("sw_l0", 32'(lane(0)), 32'h62);
        checkOutput("sw_l2", 32'(lane(2)), 32'h61);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        tick();

        // Reset mid-operation: lanes 1 and 3 stalled, rr_ptr still 2
        applyStimulus(1'b1, 1'b1, 8'h31, 2'd1, 1'b0, 4'h5);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h33, 2'd3, 1'b0, 4'h5);
        tick();
        checkOutput("mid_v", 32'(y_valid), 32'hA);
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'd0, 1'b1, 4'h0);
        checkOutput("mid_ptr", 32'(cur_sel), 32'h2);
        tick();
        checkOutput("mid_rst_v", 32'(y_valid), 32'h0);
        checkOutput("mid_rst_d", y_data, 32'h0);
        checkOutput("mid_rst_sel", 32'(cur_sel), 32'h0);
        checkOutput("mid_rst_rdy", 32'(in_ready), 32'h1);

        // Mode switch: manual beats leave rr_ptr untouched
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h41 + i), 2'd0, 1'b1, 4'hF);
            tick();
        end
        checkOutput("ms_l2", 32'(lane(2)), 32'h43);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h44 + i), 2'd0, 1'b0, 4'hF);
            checkOutput("ms_man_sel", 32'(cur_sel), 32'h0);
            tick();
            checkOutput("ms_man_v", 32'(y_valid), 32'h1);
        end
        applyStimulus(1'b1, 1'b1, 8'h46, 2'd0, 1'b1, 4'hF);
        checkOutput("ms_auto_sel", 32'(cur_sel), 32'h3);
        tick();
        checkOutput("ms_auto_v", 32'(y_valid), 32'h8);
        checkOutput("ms_auto_d", 32'(lane(3)), 32'h46);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
        checkOutput("ms_wrap", 32'(cur_sel), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux1x4_stream.md
DEMUX1X4_STREAM -- requirements
Module: demux1x4_stream

Interface
REQ-001 The block SHALL have one parameter: W, default 8, the data width of the input and of each output lane.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, W bits: input data beat.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-007 The block SHALL have port s, input, 2 bits: manual lane select, s = k selects lane k.
REQ-008 The block SHALL have port auto, input, 1 bit: 1 selects round-robin lane selection; 0 selects manual lane selection from s.
REQ-009 The block SHALL have port y_data, output, 4*W bits: lane k data on bits [k*W +: W].
REQ-010 The block SHALL have port y_valid, output, 4 bits: per-lane output valid.
REQ-011 The block SHALL have port y_ready, input, 4 bits: per-lane downstream ready.
REQ-012 The block SHALL have port cur_sel, output, 2 bits: the effective lane select this cycle.

Function
REQ-013 Effective select esel SHALL be rr_ptr when auto=1 and s when auto=0, combinationally; cur_sel SHALL equal esel.
REQ-014 Each lane SHALL own a one-entry output register holding a data word and a valid flag; y_valid[k] and y_data lane k SHALL come directly from that register.
REQ-015 in_ready SHALL equal (!y_valid[esel] || y_ready[esel]); it is combinational and SHALL NOT depend on in_valid.
REQ-016 An input beat SHALL be accepted on a cycle where in_valid=1 and in_ready=1; on that edge, lane esel SHALL load in_data and set its valid flag.
REQ-017 Latency from accept to y_valid/y_data on the target lane SHALL be exactly 1 cycle.
REQ-018 A lane SHALL drain on a cycle where y_valid[k]=1 and y_ready[k]=1; on that edge, with no load into the same lane, its valid flag SHALL clear and its data SHALL hold.
REQ-019 Simultaneous drain and load of the same lane SHALL leave y_valid[k]=1 with the new data, with no bubble and no lost beat.
REQ-020 Lanes other than esel SHALL keep their contents; they drain independently, including in the same cycle as a load into esel.
REQ-021 rr_ptr SHALL be a 2-bit counter that increments by 1 on each accepted beat while auto=1 and wraps from 3 to 0.
REQ-022 rr_ptr SHALL hold when auto=0 or when no beat is accepted; toggling auto SHALL NOT modify rr_ptr.
REQ-023 A change of s or auto while in_valid=1 and in_ready=0 SHALL be permitted; the beat SHALL route to the esel value of the accept cycle.
REQ-024 When lane esel is full and not draining, in_ready SHALL be 0 even if other lanes are empty; there is no head-of-line bypass.
REQ-025 y_data of a lane SHALL hold its value while y_valid is 1 and y_ready is 0.

Reset
REQ-026 On a clk edge with rst_n=0, all lane valid flags SHALL clear to 0, all lane data SHALL clear to 0, and rr_ptr SHALL clear to 0, regardless of in-flight traffic.
REQ-027 During and after reset, in_ready SHALL be 1, since all lanes are empty; beats presented while rst_n=0 SHALL NOT be stored.
REQ-028 The first edge with rst_n=1 SHALL operate normally; there SHALL be no extra wait cycles.

Verification
REQ-029 Manual routing: auto=0, y_ready=4'hF; send 0xA1 with s=0, 0xB2 with s=1, 0xC3 with s=2, 0xD4 with s=3 on consecutive cycles -> each lane shows its beat 1 cycle later, one cycle each, and in_ready stays 1.
REQ-030 Round-robin wrap: auto=1, y_ready=4'hF, 6 consecutive beats 0x01..0x06 -> lanes 0,1,2,3,0,1, cur_sel sequence 0,1,2,3,0,1, and final rr_ptr=2.
REQ-031 Backpressure: auto=0, s=2, y_ready[2]=0; send 0x11 then 0x22 -> lane 2 holds 0x11 and in_ready=0 while 0x22 waits; raise y_ready[2] -> the same edge drains 0x11 and loads 0x22, and y_valid[2] stays 1.
REQ-032 Independence: lane 0 full with y_ready[0]=0, s=1, send 0x5A -> accepted into lane 1 and lane 0 is unchanged; switching to s=0 -> in_ready=0.
REQ-033 Mode switch: auto=1, 3 beats accepted (rr_ptr=3), auto=0 with s=0 for 2 beats, then auto=1 -> next beat goes to lane 3.
REQ-034 Reset mid-operation: lanes 1 and 3 full and stalled, rr_ptr=2; assert rst_n=0 for 1 edge -> y_valid=0, y_data=0, cur_sel=0 (auto=1), and in_ready=1.
